deserializador4b: RTL and testbench

Serial-to-parallel receiver for the shift-register datapath. Accepts the serial bit stream produced at a shift register's serial output, assembles it into WIDTH-bit words in either bit order, and buffers completed words in a small FIFO. Words are presented to a downstream consumer over a valid/ready handshake. It is the receive end of the serial link whose transmit end is the 4-bit shift register.

---
 rtl/registro_pkg.sv | 16 +
 rtl/deserializador4b_fifo_rx.sv | 48 ++++
 rtl/deserializador4b.sv | 93 +++++++++
 tb/tb_deserializador4b.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/registro_pkg.sv
// Shared definitions for the serial link: FSM states, bit-order codes and
// default geometry of the receiver.
package registro_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 2;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

endpackage

// File: rtl/deserializador4b_fifo_rx.sv
// Small synchronous word FIFO; the head entry is always visible on head, so
// a pop at edge N exposes the next word right after that edge.
module fifo_rx #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only taken when the head leaves at the same edge.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_q];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (do_pop) rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, do_push} - {{(CNT_W-1){1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/deserializador4b.sv
// Serial-to-parallel receiver: frames the incoming bit stream into WIDTH-bit
// words in either bit order and queues them for a valid/ready consumer.
module deserializador4b
  import registro_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enb,
  input  logic             dir,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, cnt_base;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, full, empty;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      overflow_q <= overflow_d;
    end
  end

  // start realigns the frame first, so a bit arriving with it lands as bit 0.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    cnt_base  = bit_cnt_q;
    push      = 1'b0;
    if (enb) begin
      if (start) begin
        state_d  = ST_RECV;
        cnt_base = '0;
      end
      bit_cnt_d = cnt_base;
      if (s_valid && (state_q == ST_RECV || start)) begin
        if (dir == DIR_MSB_FIRST) sh_d = {sh_q[WIDTH-2:0], s_in};
        else                      sh_d = {s_in, sh_q[WIDTH-1:1]};
        if (cnt_base == LAST) begin
          push      = 1'b1;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = cnt_base + CNT_W'(1);
        end
      end
    end
  end

  assign pop        = q_valid && q_ready;
  assign overflow_d = overflow_q || (push && full && !pop);

  fifo_rx #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_L(reset_L),
    .push   (push),
    .din    (sh_d),
    .pop    (pop),
    .head   (q),
    .full   (full),
    .empty  (empty)
  );

  assign q_valid  = !empty;
  assign busy     = (state_q == ST_RECV) && (bit_cnt_q != '0);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_deserializador4b.sv
// Directed bench for deserializador4b with a queue of expected words.
module tb_deserializador4b;

  logic       clk = 1'b0;
  logic       reset_L, enb, dir, s_in, s_valid, start, q_ready;
  logic [3:0] q;
  logic       q_valid, busy, overflow;
  logic [3:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  deserializador4b #(.WIDTH(4), .DEPTH(2)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .enb     (enb),
    .dir     (dir),
    .s_in    (s_in),
    .s_valid (s_valid),
    .start   (start),
    .q       (q),
    .q_valid (q_valid),
    .q_ready (q_ready),
    .busy    (busy),
    .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic send_bit(input logic b, input logic d, input logic st);
    enb = 1'b1; s_valid = 1'b1; s_in = b; dir = d; start = st;
    @(posedge clk); #1;
    s_valid = 1'b0; start = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [3:0] w, input logic d, input logic st);
    for (int i = 0; i < 4; i++)
      send_bit(d ? w[i] : w[3-i], d, st && (i == 0));
  endtask

  task automatic pop_check(input string tag);
    check({tag, "_valid"}, 32'(q_valid), 32'd1);
    if (exp_q.size() > 0) begin
      check(tag, 32'(q), 32'(exp_q.pop_front()));
    end else begin
      checks++;
      errors++;
      $error("FAIL %s: observed %0h expected no word", tag, q);
    end
    q_ready = 1'b1;
    @(posedge clk); #1;
    q_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    reset_L = 1'b0; enb = 1'b0; dir = 1'b0; s_in = 1'b0;
    s_valid = 1'b0; start = 1'b0; q_ready = 1'b0;

    // Reset with inputs toggling
    for (int i = 0; i < 6; i++) begin
      enb = 1'($urandom); dir = 1'($urandom); s_in = 1'($urandom);
      s_valid = 1'($urandom); start = 1'($urandom); q_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    check("rst_q", 32'(q), 32'd0);
    check("rst_q_valid", 32'(q_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    enb = 1'b0; s_valid = 1'b0; start = 1'b0; q_ready = 1'b0;
    #1 reset_L = 1'b1;
    idle_cycle();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
    check("idle_no_word", 32'(q_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // MSB first 1,0,1,1
    exp_q.push_back(4'b1011);
    send_bit(1'b1, 1'b0, 1'b1); check("msb_busy1", 32'(busy), 32'd1);
    send_bit(1'b0, 1'b0, 1'b0); check("msb_busy2", 32'(busy), 32'd1);
    send_bit(1'b1, 1'b0, 1'b0); check("msb_busy3", 32'(busy), 32'd1);
    check("msb_not_yet", 32'(q_valid), 32'd0);
    send_bit(1'b1, 1'b0, 1'b0); check("msb_busy4", 32'(busy), 32'd0);
    pop_check("msb_word");
    check("msb_empty", 32'(q_valid), 32'd0);

    // LSB first with gaps and an enb=0 cycle
    exp_q.push_back(4'b1101);
    send_bit(1'b1, 1'b1, 1'b1);
    idle_cycle();
    send_bit(1'b0, 1'b1, 1'b0);
    enb = 1'b0; s_valid = 1'b1; s_in = 1'b0; start = 1'b1;
    idle_cycle();
    s_valid = 1'b0; start = 1'b0;
    check("lsb_hold_busy", 32'(busy), 32'd1);
    send_bit(1'b1, 1'b1, 1'b0);
    idle_cycle();
    check("lsb_not_yet", 32'(q_valid), 32'd0);
    send_bit(1'b1, 1'b1, 1'b0);
    pop_check("lsb_word");

    // Overflow with consumer stalled
    exp_q.push_back(4'hA);
    exp_q.push_back(4'h5);
    send_word(4'hA, 1'b0, 1'b1); check("ovf_after_a", 32'(overflow), 32'd0);
    send_word(4'h5, 1'b0, 1'b0); check("ovf_after_5", 32'(overflow), 32'd0);
    send_word(4'hC, 1'b0, 1'b0); check("ovf_after_c", 32'(overflow), 32'd1);
    pop_check("ovf_pop_a");
    pop_check("ovf_pop_5");
    check("ovf_drained", 32'(q_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with pop on the completing edge
    do_reset();
    check("full_ovf_clear", 32'(overflow), 32'd0);
    exp_q.push_back(4'hA);
    exp_q.push_back(4'h5);
    send_word(4'hA, 1'b0, 1'b1);
    send_word(4'h5, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    check("full_head_a", 32'(q), 32'(exp_q.pop_front()));
    q_ready = 1'b1;
    send_bit(1'b0, 1'b0, 1'b0);
    q_ready = 1'b0;
    exp_q.push_back(4'hC);
    check("full_no_ovf", 32'(overflow), 32'd0);
    pop_check("full_pop_5");
    pop_check("full_pop_c");
    check("full_drained", 32'(q_valid), 32'd0);

    // Realign mid-word, then reset mid-word with a buffered word
    exp_q.push_back(4'b1001);
    send_bit(1'b1, 1'b0, 1'b1);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    check("realign_not_yet", 32'(q_valid), 32'd0);
    send_bit(1'b1, 1'b0, 1'b0);
    pop_check("realign_word");
    send_word(4'h6, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_valid", 32'(q_valid), 32'd1);
    #2 reset_L = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(q_valid), 32'd0);
    check("mid_rst_q", 32'(q), 32'd0);
    exp_q.delete();
    @(posedge clk); #1 reset_L = 1'b1;
    idle_cycle();
    check("post_rst_ovf", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
